add_seq_ctrl: RTL

Byte-serial sequencer that computes wide add/subtract using a single shared 8-bit adder slice (sum/cout = a + b + cin).
- Accepts NBYTES-wide operands on a start pulse.
- Steps one byte per clock, least-significant byte first, chaining the carry between steps.
- Presents the full result with a one-cycle done pulse.
- Sits between the control/host logic and the 8-bit add datapath, so wide arithmetic needs no wide adder.

---
 rtl/add_seq_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/add_seq_ctrl.sv
// -----------------------------------------------------------------------------
// add_seq_ctrl
//   Byte-serial wide add/subtract sequencer. Operands NBYTES*8 bits wide are
//   latched on an accepted start. A single 8-bit adder slice then processes
//   one byte per clock, least-significant byte first, and chains the carry.
//   A one-cycle done pulse marks a valid sum/cout. Subtraction is computed
//   as a + ~b + 1.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous reset, active-high
//   start  in   request an operation; taken only when busy=0
//   sub    in   0: a + b + cin, 1: a - b (sampled with start)
//   a, b   in   W-bit operands (sampled with start)
//   cin    in   carry-in for add, ignored for subtract (sampled with start)
//   busy   out  high while slices are being processed
//   done   out  one-cycle pulse, sum/cout valid
//   sum    out  W-bit result, held until the next completion
//   cout   out  final carry (subtract: 1 = no borrow)
// -----------------------------------------------------------------------------
module add_seq_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout
);

  localparam int W    = 8 * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state;
  logic [IDXW-1:0] idx;
  logic            carry;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic [W-1:0]    part;

  logic [7:0]      a_byte;
  logic [7:0]      b_byte;
  logic [8:0]      slice;
  logic [W-1:0]    part_next;
  logic            last;
  logic            accept;

  // Status flags decode straight from state so an async reset clears them
  // without waiting for an edge.
  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  // The shared 8-bit slice: the only adder in the design.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    a_byte    = op_a[8*idx +: 8];
    b_byte    = op_b[8*idx +: 8];
    slice     = {1'b0, a_byte} + {1'b0, b_byte} + {8'd0, carry};
    part_next = part;
    part_next[8*idx +: 8] = slice[7:0];
    last      = (idx == IDXW'(NBYTES - 1));
    accept    = start && (state != S_RUN);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: the operand/partial registers are plain flops, not a memory array,
  // so clearing them on reset is cheap and removes any residue from an
  // aborted operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
      carry <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
      part  <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            op_a  <= a;
            // Subtract as a + ~b + 1; the carry-in supplies the +1.
            op_b  <= sub ? ~b : b;
            carry <= sub | cin;
            idx   <= '0;
            part  <= '0;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          part  <= part_next;
          carry <= slice[8];
          idx   <= idx + 1'b1;
          if (last) begin
            // part_next already holds the byte computed on this edge.
            sum   <= part_next;
            cout  <= slice[8];
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
